// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared core definitions for the register-file write arbiter: data width
// default, register-file geometry and the controller state encoding.
package regfile_wr_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NUM_REGS     = 32;
    localparam int REG_IDX_W    = $clog2(NUM_REGS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Round-robin grant: starting at the pointer, the first asserted request
// (wrapping around) wins. The grant is one-hot or all-zero.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] pointer_i,
    output logic [NREQ-1:0]  grant_o
);

    logic found;
    int   idx;

    // Scan requesters in priority order beginning at the pointer.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(pointer_i) + off) % NREQ;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write arbiter: picks one of NREQ writers per cycle in
// round-robin order and registers the winning write into a single output
// stage. A scrub sequence can take over the write port to zero x1..x31.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [REG_IDX_W*NREQ-1:0] req_rd,
    input  logic [XLEN*NREQ-1:0]      req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      scrub_start,
    output logic                      scrub_busy,
    output logic                      rf_enable,
    output logic [REG_IDX_W-1:0]      rf_rd_select,
    output logic [XLEN-1:0]           rf_data_in,
    output logic [NUM_REGS-1:0]       pending_mask
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [REG_IDX_W-1:0]   cnt_q, cnt_d;
    logic                   en_q, en_d;
    logic [REG_IDX_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]        data_q, data_d;

    logic [NREQ-1:0]        grant;
    logic                   accept_open;
    logic                   transfer;
    logic [REG_IDX_W-1:0]   sel_rd;
    logic [XLEN-1:0]        sel_data;
    logic [PTR_W-1:0]       sel_idx;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req_i     (req_valid),
        .pointer_i (ptr_q),
        .grant_o   (grant)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scrub leaves once the counter has wrapped past x31 back to zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (scrub_start) state_d = SCRUB;
            SCRUB:   if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Requesters are only served in IDLE, out of reset, and not while a scrub is being launched.
    always_comb begin
        accept_open = reset && (state_q == IDLE) && !scrub_start;
        req_ready   = accept_open ? grant : '0;
        scrub_busy  = (state_q == SCRUB);
    end

    assign transfer = |(req_valid & req_ready);

    // Pull index, destination and data of the granted requester.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        sel_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[REG_IDX_W*i +: REG_IDX_W];
                sel_data = req_data[XLEN*i +: XLEN];
                sel_idx  = PTR_W'(i);
            end
        end
    end

    // Next values for pointer, scrub counter and output stage; x0 writes are swallowed.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        en_d   = 1'b0;
        rd_d   = '0;
        data_d = '0;
        case (state_q)
            IDLE: begin
                if (scrub_start) begin
                    en_d  = 1'b1;
                    rd_d  = REG_IDX_W'(1);
                    cnt_d = REG_IDX_W'(2);
                end else if (transfer) begin
                    ptr_d = (int'(sel_idx) == NREQ - 1) ? '0 : sel_idx + 1'b1;
                    if (sel_rd != '0) begin
                        en_d   = 1'b1;
                        rd_d   = sel_rd;
                        data_d = sel_data;
                    end
                end
            end
            SCRUB: begin
                if (cnt_q != '0) begin
                    en_d  = 1'b1;
                    rd_d  = cnt_q;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pointer, counter and output stage registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign rf_enable    = en_q;
    assign rf_rd_select = rd_q;
    assign rf_data_in   = data_q;
    assign pending_mask = en_q ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << rd_q) : '0;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (NREQ=3, XLEN=32).
module tb_regfile_wr_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_rd;
    logic [XLEN*NREQ-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 scrub_start;
    logic                 scrub_busy;
    logic                 rf_enable;
    logic [4:0]           rf_rd_select;
    logic [XLEN-1:0]      rf_data_in;
    logic [31:0]          pending_mask;

    int testCount;
    int failCount;

    regfile_wr_arbiter #(
        .NREQ (NREQ),
        .XLEN (XLEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .scrub_start  (scrub_start),
        .scrub_busy   (scrub_busy),
        .rf_enable    (rf_enable),
        .rf_rd_select (rf_rd_select),
        .rf_data_in   (rf_data_in),
        .pending_mask (pending_mask)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive all inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic rst, input logic scrub, input logic [2:0] valid,
                                 input logic [4:0] rd0, input logic [4:0] rd1, input logic [4:0] rd2,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        reset       = rst;
        scrub_start = scrub;
        req_valid   = valid;
        req_rd      = {rd2, rd1, rd0};
        req_data    = {d2, d1, d0};
        #1;
    endtask

    // Step to a point safely after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // All three requesters active with rd = 10+i and data = 0x100+i.
    task automatic allValid(input logic rst, input logic scrub);
        applyStimulus(rst, scrub, 3'b111, 5'd10, 5'd11, 5'd12, 32'h100, 32'h101, 32'h102);
    endtask

    task automatic idleInputs();
        applyStimulus(1'b1, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    logic [2:0] expGrant [6];

    initial begin
        testCount = 0;
        failCount = 0;
        expGrant  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // Reset held low two cycles with all requesters asking.
        allValid(1'b0, 1'b0);
        checkOutput("ready_in_reset0", req_ready, 3'b000);
        nextCycle();
        allValid(1'b0, 1'b0);
        checkOutput("ready_in_reset1", req_ready, 3'b000);
        nextCycle();
        allValid(1'b0, 1'b0);
        checkOutput("ready_in_reset2", req_ready, 3'b000);
        checkOutput("rst_enable", rf_enable, 0);
        checkOutput("rst_rd", rf_rd_select, 0);
        checkOutput("rst_data", rf_data_in, 0);
        checkOutput("rst_pending", pending_mask, 0);
        checkOutput("rst_busy", scrub_busy, 0);
        nextCycle();
        idleInputs();

        // Single write from requester 0.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
        checkOutput("single_ready", req_ready, 3'b001);
        nextCycle();
        idleInputs();
        checkOutput("single_enable", rf_enable, 1);
        checkOutput("single_rd", rf_rd_select, 5);
        checkOutput("single_data", rf_data_in, 32'hDEADBEEF);
        checkOutput("single_pending", pending_mask, 32'h20);
        nextCycle();
        checkOutput("single_enable_drop", rf_enable, 0);
        checkOutput("idle_rd_zero", rf_rd_select, 0);

        // x0 write from requester 1 is accepted but not issued.
        applyStimulus(1'b1, 1'b0, 3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0);
        checkOutput("x0_ready", req_ready, 3'b010);
        nextCycle();
        idleInputs();
        checkOutput("x0_enable", rf_enable, 0);
        checkOutput("x0_pending", pending_mask, 0);
        checkOutput("x0_data", rf_data_in, 0);

        // Requester 2 alone; pointer then wraps to 0.
        applyStimulus(1'b1, 1'b0, 3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'hA5A5);
        checkOutput("r2_ready", req_ready, 3'b100);
        nextCycle();
        idleInputs();
        checkOutput("r2_rd", rf_rd_select, 7);
        checkOutput("r2_pending", pending_mask, 32'h80);
        nextCycle();

        // Fairness: all requesters held six cycles, back-to-back writes.
        for (int c = 0; c < 6; c++) begin
            allValid(1'b1, 1'b0);
            checkOutput("fair_ready", req_ready, expGrant[c]);
            if (c > 0) begin
                checkOutput("fair_enable", rf_enable, 1);
                checkOutput("fair_rd", rf_rd_select, 10 + (c - 1) % 3);
                checkOutput("fair_data", rf_data_in, 32'h100 + (c - 1) % 3);
            end
            nextCycle();
        end
        idleInputs();
        checkOutput("fair_last_enable", rf_enable, 1);
        checkOutput("fair_last_rd", rf_rd_select, 12);

        // Idle cycles leave pointer at 0; one write by requester 0 moves it to 1.
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'b011, 5'd3, 5'd4, 5'd0, 32'h33, 32'h44, 32'h0);
        checkOutput("pre_scrub_ready", req_ready, 3'b001);
        nextCycle();

        // Scrub with all requesters active; second pulse mid-scrub is ignored.
        allValid(1'b1, 1'b1);
        checkOutput("scrub_pulse_ready", req_ready, 3'b000);
        checkOutput("scrub_pulse_busy", scrub_busy, 0);
        checkOutput("scrub_pulse_rd", rf_rd_select, 3);
        for (int k = 1; k <= 31; k++) begin
            nextCycle();
            allValid(1'b1, k == 5);
            checkOutput("scrub_ready", req_ready, 3'b000);
            checkOutput("scrub_busy", scrub_busy, 1);
            checkOutput("scrub_enable", rf_enable, 1);
            checkOutput("scrub_rd", rf_rd_select, k);
            checkOutput("scrub_data", rf_data_in, 0);
            checkOutput("scrub_pending", pending_mask, 64'(32'h1 << k));
        end
        nextCycle();
        allValid(1'b1, 1'b0);
        checkOutput("post_scrub_busy", scrub_busy, 0);
        checkOutput("post_scrub_enable", rf_enable, 0);
        checkOutput("post_scrub_ready", req_ready, 3'b010);
        nextCycle();
        idleInputs();
        checkOutput("post_scrub_rd", rf_rd_select, 11);
        checkOutput("post_scrub_data", rf_data_in, 32'h101);
        nextCycle();

        // Reset during scrub at the x10 write.
        allValid(1'b1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            nextCycle();
            allValid(k != 10, 1'b0);
        end
        checkOutput("abort_rd_at_reset", rf_rd_select, 10);
        nextCycle();
        allValid(1'b0, 1'b0);
        checkOutput("abort_enable", rf_enable, 0);
        checkOutput("abort_busy", scrub_busy, 0);
        checkOutput("abort_rd", rf_rd_select, 0);
        nextCycle();
        allValid(1'b1, 1'b0);
        checkOutput("abort_ptr_ready", req_ready, 3'b001);
        checkOutput("abort_no_scrub", rf_enable, 0);
        nextCycle();
        idleInputs();
        checkOutput("abort_write_rd", rf_rd_select, 10);
        checkOutput("abort_write_busy", scrub_busy, 0);
        nextCycle();
        checkOutput("abort_quiet", rf_enable, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 3, number of write requesters; XLEN, default 32, data width.
REQ-002 Port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port reset  input  1  synchronous, active-low reset: sampled on clk rising edge, reset when 0.
REQ-004 Port req_valid  input  NREQ  per-requester write request.
REQ-005 Port req_rd  input  5*NREQ  destination register index; slice i = bits [5i+4:5i].
REQ-006 Port req_data  input  XLEN*NREQ  write data; slice i = bits [XLEN*i+XLEN-1:XLEN*i].
REQ-007 Port req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] && req_ready[i].
REQ-008 Port scrub_start  input  1  single-cycle pulse requesting zeroing of x1..x31.
REQ-009 Port scrub_busy  output  1  high while the scrub sequence runs.
REQ-010 Port rf_enable  output  1  register-file write enable.
REQ-011 Port rf_rd_select  output  5  register-file write index.
REQ-012 Port rf_data_in  output  XLEN  register-file write data.
REQ-013 Port pending_mask  output  32  bit r high when a write to xr sits in the output stage this cycle.

Function
REQ-014 FSM SHALL have states IDLE and SCRUB; IDLE->SCRUB on scrub_start; SCRUB->IDLE after the x31 write is issued.
REQ-015 In IDLE, req_ready SHALL be a combinational round-robin grant over req_valid, at most one bit high.
REQ-016 Round-robin pointer SHALL start at requester 0; after a transfer by requester g it SHALL become (g+1) mod NREQ; it SHALL not move on idle cycles.
REQ-017 Granted request SHALL be registered: rf_enable/rf_rd_select/rf_data_in reflect it exactly one cycle after the transfer (latency 1), rf_enable high for one cycle.
REQ-018 Throughput SHALL be one write per cycle; back-to-back transfers SHALL produce back-to-back rf_enable pulses.
REQ-019 Transfer with rd=0 SHALL be accepted (ready high) but SHALL NOT raise rf_enable the following cycle.
REQ-020 When rf_enable is low, rf_rd_select and rf_data_in SHALL be 0.
REQ-021 pending_mask SHALL equal (rf_enable ? 1<<rf_rd_select : 0).
REQ-022 In SCRUB, req_ready SHALL be all-zero; a 5-bit counter SHALL issue rf_enable with rf_data_in=0 and rf_rd_select=1,2,...,31 on 31 consecutive cycles starting the cycle after scrub_start.
REQ-023 scrub_busy SHALL be high from the cycle after scrub_start through the cycle carrying the x31 write, inclusive (31 cycles).
REQ-024 scrub_start in the same cycle as a transfer: the transfer SHALL NOT occur (ready forced 0 that cycle); scrub takes precedence.
REQ-025 scrub_start while in SCRUB SHALL be ignored (no restart, no extension).
REQ-026 Round-robin pointer SHALL be held unchanged across a scrub.

Reset
REQ-027 On reset low at a clk edge: state=IDLE, pointer=0, counter=0, output stage cleared.
REQ-028 Outputs in the cycle following reset: rf_enable=0, rf_rd_select=0, rf_data_in=0, pending_mask=0, scrub_busy=0.
REQ-029 req_ready SHALL be all-zero while reset is low.
REQ-030 Reset mid-scrub SHALL abort the sequence immediately; no further scrub writes issue.

Structure
REQ-031 XLEN default, register count (32) and FSM state encoding SHALL live in the shared core package.
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, pointer; output one-hot grant), parameterised by NREQ.

Verification
REQ-033 Single write: req_valid=001, rd=5, data=0xDEADBEEF -> ready=001 same cycle; next cycle rf_enable=1, rf_rd_select=5, rf_data_in=0xDEADBEEF, pending_mask=0x20.
REQ-034 Fairness: req_valid=111 held 6 cycles -> grants 001,010,100,001,010,100; six consecutive rf_enable pulses.
REQ-035 x0 write: requester 1 valid, rd=0, data=0x1234 -> ready=010, next cycle rf_enable=0, pending_mask=0.
REQ-036 Scrub: scrub_start pulse with req_valid=111 -> req_ready=000 for 32 cycles (pulse cycle + 31 busy), rd 1..31 written with 0, scrub_busy 31 cycles, then grant resumes at pre-scrub pointer.
REQ-037 Reset mid-scrub: reset low at scrub write to x10 -> next cycle rf_enable=0, scrub_busy=0, state IDLE, pointer 0.
REQ-038 Reset idle outputs: reset low 2 cycles with req_valid=111 -> req_ready=000, all outputs 0.
